mmss_timer_counter: RTL

//  Parametrised base-60 BCD time counter: successor to the fixed 4-digit mm:ss stopwatch counter.

---
 rtl/mmss_timer_counter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mmss_timer_counter.sv
// mmss_timer_counter: base-60 BCD time counter (NUM_PAIRS pairs of tens 0-5 / units 0-9).
// Counts up or down on a single-cycle tick. Supports pause, clamped load, clear,
// and either roll-over or saturation at the limits.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   tick              count enable, one cycle wide
//   pause             level, 1 = ignore tick
//   dir               0 = up, 1 = down (sampled on tick edges)
//   clear             synchronous clear to zero (highest after rst)
//   load, load_val    synchronous load; each digit is clamped to valid BCD
//   cnt               packed pairs, pair k = {tens[7k+6:7k+4], units[7k+3:7k]}
//   at_zero, at_max   combinational decodes of the registered cnt
//   wrap              registered 1-cycle pulse after a roll-over
//   done              registered sticky flag, set when a saturating limit is hit
module mmss_timer_counter #(
  parameter int unsigned NUM_PAIRS = 2,
  parameter int unsigned WRAP_MODE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   pause,
  input  logic                   dir,
  input  logic                   clear,
  input  logic                   load,
  input  logic [7*NUM_PAIRS-1:0] load_val,
  output logic [7*NUM_PAIRS-1:0] cnt,
  output logic                   at_zero,
  output logic                   at_max,
  output logic                   wrap,
  output logic                   done
);

  localparam int unsigned W = 7 * NUM_PAIRS;
  // 7'h59 packs tens=5 (bits 6:4) and units=9 (bits 3:0).
  localparam logic [W-1:0] MAX_CNT = {NUM_PAIRS{7'h59}};

  logic [W-1:0] cnt_up;
  logic [W-1:0] cnt_dn;
  logic [W-1:0] load_clamp;
  logic         carry_out;
  logic         borrow_out;

  // Per-digit increment/decrement with ripple carry/borrow, and load clamping.
  always_comb begin
    cnt_up     = cnt;
    cnt_dn     = cnt;
    load_clamp = '0;
    carry_out  = 1'b1;
    borrow_out = 1'b1;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      if (carry_out) begin
        if (cnt[7*k +: 4] == 4'd9) begin
          cnt_up[7*k +: 4] = 4'd0;
          if (cnt[7*k+4 +: 3] == 3'd5) begin
            cnt_up[7*k+4 +: 3] = 3'd0;
          end else begin
            cnt_up[7*k+4 +: 3] = cnt[7*k+4 +: 3] + 3'd1;
            carry_out          = 1'b0;
          end
        end else begin
          cnt_up[7*k +: 4] = cnt[7*k +: 4] + 4'd1;
          carry_out        = 1'b0;
        end
      end

      if (borrow_out) begin
        if (cnt[7*k +: 4] == 4'd0) begin
          cnt_dn[7*k +: 4] = 4'd9;
          if (cnt[7*k+4 +: 3] == 3'd0) begin
            cnt_dn[7*k+4 +: 3] = 3'd5;
          end else begin
            cnt_dn[7*k+4 +: 3] = cnt[7*k+4 +: 3] - 3'd1;
            borrow_out         = 1'b0;
          end
        end else begin
          cnt_dn[7*k +: 4] = cnt[7*k +: 4] - 4'd1;
          borrow_out       = 1'b0;
        end
      end

      load_clamp[7*k +: 4]   = (load_val[7*k +: 4] > 4'd9) ? 4'd9 : load_val[7*k +: 4];
      load_clamp[7*k+4 +: 3] = (load_val[7*k+4 +: 3] > 3'd5) ? 3'd5 : load_val[7*k+4 +: 3];
    end
  end

  // Counter state: clear > load > count > hold. wrap defaults low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      wrap <= 1'b0;
      done <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        cnt  <= '0;
        done <= 1'b0;
      end else if (load) begin
        cnt  <= load_clamp;
        done <= 1'b0;
      end else if (tick && !pause) begin
        if (!dir) begin
          if (carry_out) begin
            // Carry out of the top pair: cnt was at max.
            if (WRAP_MODE != 0) begin
              cnt  <= '0;
              wrap <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else begin
            cnt <= cnt_up;
          end
        end else begin
          if (borrow_out) begin
            // Borrow out of the top pair: cnt was zero.
            if (WRAP_MODE != 0) begin
              cnt  <= MAX_CNT;
              wrap <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else begin
            cnt <= cnt_dn;
          end
        end
      end
    end
  end

  assign at_zero = (cnt == '0);
  assign at_max  = (cnt == MAX_CNT);

endmodule
